// File: rtl/motor_pkg.sv
// Shared definitions for the stepper step-rate generator: state encoding,
// default widths and the shortest legal step period.
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_PER_W = 16;
  localparam int MIN_PER   = 2;

endpackage

// File: rtl/motor_step_ctrl_if.sv
// Host-side command/status bundle of the step-rate generator.
interface motor_step_ctrl_if
  import motor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PER_W = DEF_PER_W
);
  logic             start;
  logic             abort;
  logic             dir_in;
  logic [CNT_W-1:0] nsteps;
  logic [PER_W-1:0] per_start;
  logic [PER_W-1:0] per_min;
  logic [PER_W-1:0] per_dec;
  logic             step;
  logic             dir_o;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rem;

  modport master (
    output start, abort, dir_in, nsteps, per_start, per_min, per_dec,
    input  step, dir_o, busy, done, rem
  );

  modport slave (
    input  start, abort, dir_in, nsteps, per_start, per_min, per_dec,
    output step, dir_o, busy, done, rem
  );
endinterface

// File: rtl/step_timer.sv
// Loadable down-counter; expire is high in the last cycle of a loaded period.
module step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic [PER_W-1:0] load_val,
  output logic             expire
);
  logic [PER_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  // A load of P makes expire rise P-1 edges later, so the step lands P edges out.
  assign expire = (cnt == PER_W'(1));
endmodule

// File: rtl/motor_step_ctrl.sv
// Trapezoidal step-rate generator: issues one-cycle step strobes whose spacing
// ramps from per_start down to per_min and back, with busy/done to the host.
module motor_step_ctrl
  import motor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PER_W = DEF_PER_W
) (
  input logic              CP,
  input logic              CR,
  motor_step_ctrl_if.slave bus
);
  typedef struct packed {
    logic [PER_W-1:0] ps;
    logic [PER_W-1:0] pm;
    logic [PER_W-1:0] pd;
  } prof_t;

  state_t           state, state_n;
  prof_t            prof_q, prof_n;
  logic [PER_W-1:0] cur_per, cur_n, tmr_val, per_up, per_dn;
  logic [PER_W:0]   sum_up;
  logic [CNT_W-1:0] acc_cnt, acc_n, rem_q, rem_n, r;
  logic             dir_q, dir_n, busy_q, busy_n, done_q, done_n, step_q, step_n;
  logic             tmr_load, tmr_clr, expire;

  function automatic logic [PER_W-1:0] floor2(input logic [PER_W-1:0] p);
    return (p < PER_W'(MIN_PER)) ? PER_W'(MIN_PER) : p;
  endfunction

  step_timer #(.PER_W(PER_W)) u_tmr (
    .clk(CP), .rst_n(CR), .load(tmr_load), .clr(tmr_clr),
    .load_val(tmr_val), .expire(expire)
  );

  // Saturating ramp arithmetic; the add is one bit wider so it cannot wrap.
  assign sum_up = {1'b0, cur_per} + {1'b0, prof_q.pd};
  assign per_up = floor2((sum_up > {1'b0, prof_q.ps}) ? prof_q.ps : sum_up[PER_W-1:0]);
  assign per_dn = floor2((cur_per > prof_q.pm && (cur_per - prof_q.pm) > prof_q.pd)
                         ? cur_per - prof_q.pd : prof_q.pm);
  assign r      = rem_q - 1'b1;

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state   <= IDLE;
      prof_q  <= '0;
      cur_per <= '0;
      acc_cnt <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state   <= state_n;
      prof_q  <= prof_n;
      cur_per <= cur_n;
      acc_cnt <= acc_n;
      rem_q   <= rem_n;
      dir_q   <= dir_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      step_q  <= step_n;
    end
  end

  always_comb begin
    state_n  = state;
    prof_n   = prof_q;
    cur_n    = cur_per;
    acc_n    = acc_cnt;
    rem_n    = rem_q;
    dir_n    = dir_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    step_n   = 1'b0;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_val  = cur_per;
    if (state != IDLE && bus.abort) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      rem_n   = '0;
      acc_n   = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.start && bus.nsteps != '0) begin
          prof_n   = '{ps: bus.per_start, pm: bus.per_min, pd: bus.per_dec};
          cur_n    = floor2((bus.per_start > bus.per_min) ? bus.per_start : bus.per_min);
          rem_n    = bus.nsteps;
          dir_n    = bus.dir_in;
          busy_n   = 1'b1;
          acc_n    = '0;
          tmr_load = 1'b1;
          tmr_val  = cur_n;
          state_n  = (bus.per_dec == '0 || bus.per_start <= bus.per_min) ? CRUISE : ACCEL;
        end
        ACCEL, CRUISE, DECEL: if (expire) begin
          step_n = 1'b1;
          rem_n  = r;
          if (r == '0) begin
            state_n = FIN;
            tmr_clr = 1'b1;
          end else begin
            // Decel test first: short moves fold straight from ACCEL into DECEL.
            if (r <= acc_cnt && state != DECEL) begin
              state_n = DECEL;
              cur_n   = per_up;
            end else if (state == DECEL) begin
              cur_n = per_up;
            end else if (state == ACCEL) begin
              cur_n = per_dn;
              acc_n = acc_cnt + 1'b1;
              if (per_dn == prof_q.pm) state_n = CRUISE;
            end
            tmr_load = 1'b1;
            tmr_val  = cur_n;
          end
        end
        FIN: begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          acc_n   = '0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.step  = step_q;
  assign bus.dir_o = dir_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rem   = rem_q;
endmodule

// File: tb/tb_motor_step_ctrl.sv
// Randomized and directed checks of motor_step_ctrl against an interval-list model.
module tb_motor_step_ctrl;
  logic CP = 1'b0;
  logic CR = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_iv[$];

  motor_step_ctrl_if #(.CNT_W(16), .PER_W(16)) bus ();

  motor_step_ctrl #(.CNT_W(16), .PER_W(16)) dut (.CP(CP), .CR(CR), .bus(bus));

  always #5 CP = ~CP;
  always @(posedge CP) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Step-to-step gaps straight from the profile rules.
  task automatic model(input int n, input int ps, input int pm, input int pd);
    int cur, acc, r;
    bit accel, decel;
    exp_iv.delete();
    cur   = (ps > pm) ? ps : pm;
    if (cur < 2) cur = 2;
    accel = (pd != 0 && ps > pm);
    decel = 0;
    acc   = 0;
    for (int k = 1; k <= n; k++) begin
      exp_iv.push_back(cur);
      r = n - k;
      if (r == 0) break;
      if (!decel && r <= acc) begin
        decel = 1;
        accel = 0;
        cur = (cur + pd > ps) ? ps : cur + pd;
      end else if (decel) begin
        cur = (cur + pd > ps) ? ps : cur + pd;
      end else if (accel) begin
        cur = (cur - pd < pm) ? pm : cur - pd;
        acc++;
        if (cur == pm) accel = 0;
      end
      if (cur < 2) cur = 2;
    end
  endtask

  task automatic run_move(input bit d, input int n, input int ps, input int pm,
                          input int pd, input int abort_k, input bit mid_start);
    int got[$];
    int t_done = -1;
    int acc, total, budget, nexp, tsum;
    bit aborted = 0;
    model(n, ps, pm, pd);
    total = 0;
    foreach (exp_iv[i]) total += exp_iv[i];
    budget = total + 8;
    @(negedge CP);
    bus.dir_in = d; bus.nsteps = 16'(n); bus.per_start = 16'(ps);
    bus.per_min = 16'(pm); bus.per_dec = 16'(pd); bus.start = 1'b1;
    @(posedge CP); #1;
    acc = cyc;
    @(negedge CP);
    bus.start = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    for (int c = 0; c < budget; c++) begin
      bus.start = 1'b0;
      if (bus.step) begin
        got.push_back(cyc - acc);
        chk("rem_at_step", bus.rem, n - got.size());
        chk("dir_o", bus.dir_o, d);
        if (mid_start && got.size() == 2) begin
          bus.dir_in = !d; bus.nsteps = 16'(n + 3); bus.start = 1'b1;
        end
      end
      if (bus.done) begin
        t_done = cyc - acc;
        chk("busy_at_done", bus.busy, 0);
        chk("rem_at_done", bus.rem, 0);
        break;
      end
      if (abort_k != 0 && got.size() == abort_k && !aborted) begin
        aborted = 1;
        bus.abort = 1'b1;
        @(negedge CP);
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_rem", bus.rem, 0);
        chk("abort_step", bus.step, 0);
        chk("abort_done", bus.done, 0);
        break;
      end
      @(negedge CP);
    end
    nexp = (abort_k != 0) ? abort_k : n;
    chk("step_count", got.size(), nexp);
    tsum = 0;
    for (int i = 0; i < nexp && i < got.size(); i++) begin
      tsum += exp_iv[i];
      chk("step_time", got[i], tsum);
    end
    if (abort_k == 0) chk("done_time", t_done, total + 1);
    else              chk("no_done", t_done, -1);
  endtask

  initial begin
    int n, pm, ps, pd, nst, ndn;
    bus.start = 0; bus.abort = 0; bus.dir_in = 0; bus.nsteps = 0;
    bus.per_start = 0; bus.per_min = 0; bus.per_dec = 0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rem", bus.rem, 0);
    chk("rst_dir", bus.dir_o, 0);
    repeat (2) @(negedge CP);
    CR = 1'b1;

    run_move(0, 4, 5, 5, 0, 0, 0);     // constant speed
    run_move(0, 10, 8, 4, 2, 0, 0);    // trapezoid
    run_move(1, 3, 8, 4, 2, 0, 0);     // triangle
    run_move(1, 6, 5, 5, 0, 0, 1);     // start while busy ignored

    @(negedge CP);
    bus.nsteps = 0; bus.start = 1'b1;
    @(negedge CP);
    bus.start = 1'b0;
    repeat (3) @(negedge CP);
    chk("zero_steps_busy", bus.busy, 0);
    chk("zero_steps_done", bus.done, 0);

    run_move(0, 10, 8, 4, 2, 3, 0);    // abort after the third step
    run_move(0, 10, 8, 4, 2, 0, 0);    // immediate restart runs normally

    // Asynchronous reset in the middle of a move
    @(negedge CP);
    bus.dir_in = 1; bus.nsteps = 4; bus.per_start = 5; bus.per_min = 5;
    bus.per_dec = 0; bus.start = 1'b1;
    @(negedge CP);
    bus.start = 1'b0;
    repeat (7) @(negedge CP);
    chk("pre_rst_busy", bus.busy, 1);
    #2 CR = 1'b0;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_dir", bus.dir_o, 0);
    chk("async_rem", bus.rem, 0);
    chk("async_step", bus.step, 0);
    chk("async_done", bus.done, 0);
    repeat (3) @(negedge CP);
    CR = 1'b1;
    nst = 0; ndn = 0;
    repeat (40) begin
      @(negedge CP);
      nst += int'(bus.step);
      ndn += int'(bus.done);
    end
    chk("post_rst_steps", nst, 0);
    chk("post_rst_dones", ndn, 0);
    run_move(1, 4, 5, 5, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      n  = $urandom_range(12, 1);
      pm = $urandom_range(6, 2);
      ps = $urandom_range(pm + 10, (pm > 3) ? pm - 2 : 2);
      pd = $urandom_range(4, 0);
      run_move(1'($urandom_range(1, 0)), n, ps, pm, pd,
               ($urandom_range(4, 0) == 0 && n > 1) ? $urandom_range(n - 1, 1) : 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
